// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: hunts for 0x55 0xAA LEN payload CHK frames coming from a UART
// receiver, buffers the payload, verifies the additive checksum and then replays the payload
// on a valid/ready stream. Aborted frames raise a one-cycle frame_err with a held cause code.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 52080
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic       rx_check_err,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       byte_drop
);

  // Pointer holds 0..MAX_LEN-1; the buffer is rounded up to a power of two so any pointer
  // value is a legal index.
  localparam int unsigned PtrW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned Depth = 1 << PtrW;
  // Timeout counter only ever needs to reach TIMEOUT_CYC-1.
  localparam int unsigned TmoW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ErrTimeout = 2'd0;
  localparam logic [1:0] ErrLength  = 2'd1;
  localparam logic [1:0] ErrChksum  = 2'd2;
  localparam logic [1:0] ErrParity  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StHdr2,
    StLen,
    StPayload,
    StChk,
    StOut
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;    // write pointer while collecting, read pointer while replaying
  logic [PtrW-1:0]   last_q;   // index of the final payload byte (LEN-1)
  logic [7:0]        sum_q;
  logic [TmoW-1:0]   tmo_q;
  logic [7:0]        buf_q [Depth];

  logic              buf_we;
  logic [PtrW-1:0]   ptr_inc;

  assign buf_we  = (state_q == StPayload) && rx_byte_valid && !rx_check_err;
  assign ptr_inc = ptr_q + PtrW'(1);

  // Payload storage; contents are only read after a full frame has been written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[ptr_q] <= rx_byte;
    end
  end

  // Frame FSM with registered stream outputs, error pulses and timeout supervision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      last_q    <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ErrTimeout;
      byte_drop <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      byte_drop <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (rx_byte_valid && (rx_byte == 8'h55)) begin
            state_q <= StHdr2;
          end
        end

        StOut: begin
          // Incoming bytes cannot be held anywhere while replaying, so they are dropped.
          if (rx_byte_valid) begin
            byte_drop <= 1'b1;
          end
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              ptr_q   <= '0;
              state_q <= StIdle;
            end else begin
              ptr_q  <= ptr_inc;
              m_data <= buf_q[ptr_inc];
              m_last <= (ptr_inc == last_q);
            end
          end
        end

        StHdr2, StLen, StPayload, StChk: begin
          if (rx_check_err) begin
            // Parity wins over whatever the byte itself would have caused.
            state_q   <= StIdle;
            frame_err <= 1'b1;
            err_code  <= ErrParity;
            tmo_q     <= '0;
          end else if (rx_byte_valid) begin
            // A byte in the timeout cycle is processed normally.
            tmo_q <= '0;
            case (state_q)
              StHdr2: begin
                if (rx_byte == 8'hAA) begin
                  state_q <= StLen;
                end else if (rx_byte != 8'h55) begin
                  state_q <= StIdle;
                end
              end
              StLen: begin
                if ((rx_byte == 8'h00) || (rx_byte > MaxLenB)) begin
                  state_q   <= StIdle;
                  frame_err <= 1'b1;
                  err_code  <= ErrLength;
                end else begin
                  last_q  <= PtrW'(rx_byte - 8'd1);
                  sum_q   <= rx_byte;
                  ptr_q   <= '0;
                  state_q <= StPayload;
                end
              end
              StPayload: begin
                sum_q <= sum_q + rx_byte;
                if (ptr_q == last_q) begin
                  state_q <= StChk;
                end else begin
                  ptr_q <= ptr_inc;
                end
              end
              StChk: begin
                if (rx_byte == sum_q) begin
                  state_q <= StOut;
                  ptr_q   <= '0;
                  m_valid <= 1'b1;
                  m_data  <= buf_q[0];
                  m_last  <= (last_q == '0);
                end else begin
                  state_q   <= StIdle;
                  frame_err <= 1'b1;
                  err_code  <= ErrChksum;
                end
              end
              default: state_q <= StIdle;
            endcase
          end else if (tmo_q == TmoLast) begin
            state_q   <= StIdle;
            frame_err <= 1'b1;
            err_code  <= ErrTimeout;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: a byte-queue reference model predicts the
// stream and error outputs every cycle, and literal logs pin each directed scenario.
module tb_uart_frame_parser;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned Tmo    = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_byte_valid = 1'b0;
  logic       rx_check_err = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       frame_err;
  logic [1:0] err_code;
  logic       byte_drop;

  uart_frame_parser #(
    .MAX_LEN    (MaxLen),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_check_err (rx_check_err),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .byte_drop    (byte_drop)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes of the frame candidate so far, and bytes still to deliver.
  logic [7:0] acc[$];
  logic [7:0] outq[$];
  int         silent = 0;
  logic       exp_err = 1'b0;
  logic       exp_drop = 1'b0;
  logic [1:0] exp_code = 2'd0;

  // Logs taken from the DUT for literal checks: {m_last, m_data} per transfer, codes per error.
  logic [8:0] got[$];
  logic [1:0] errs[$];
  int         drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic abort_frame(input logic [1:0] c);
    exp_err  = 1'b1;
    exp_code = c;
    acc.delete();
    silent = 0;
  endtask

  task automatic take_byte(input logic [7:0] b);
    int s;
    case (acc.size())
      1: begin
        if (b == 8'hAA) acc.push_back(b);
        else if (b != 8'h55) acc.delete();
      end
      2: begin
        if (b == 8'h00 || int'(b) > MaxLen) abort_frame(2'd1);
        else acc.push_back(b);
      end
      default: begin
        acc.push_back(b);
        if (acc.size() == int'(acc[2]) + 4) begin
          s = 0;
          for (int i = 2; i < acc.size() - 1; i++) s += int'(acc[i]);
          if ((s % 256) == int'(b)) begin
            for (int i = 3; i < acc.size() - 1; i++) outq.push_back(acc[i]);
            acc.delete();
          end else begin
            abort_frame(2'd2);
          end
        end
      end
    endcase
  endtask

  task automatic model_step();
    exp_err  = 1'b0;
    exp_drop = 1'b0;
    if (outq.size() > 0) begin
      if (rx_byte_valid) exp_drop = 1'b1;
      if (m_ready) void'(outq.pop_front());
    end else if (acc.size() > 0) begin
      if (rx_check_err) begin
        abort_frame(2'd3);
      end else if (rx_byte_valid) begin
        silent = 0;
        take_byte(rx_byte);
      end else begin
        silent++;
        if (silent == Tmo) abort_frame(2'd0);
      end
    end else if (rx_byte_valid && rx_byte == 8'h55) begin
      acc.push_back(8'h55);
      silent = 0;
    end
  endtask

  // Model advances on the same edges as the DUT, and clears at once on reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      acc.delete();
      outq.delete();
      silent   = 0;
      exp_err  = 1'b0;
      exp_drop = 1'b0;
      exp_code = 2'd0;
    end else begin
      model_step();
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("m_valid", m_valid, outq.size() > 0);
    if (outq.size() > 0) begin
      chk("m_data", m_data, outq[0]);
      chk("m_last", m_last, outq.size() == 1);
    end
    chk("frame_err", frame_err, exp_err);
    chk("err_code", err_code, exp_code);
    chk("byte_drop", byte_drop, exp_drop);
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    if (frame_err) errs.push_back(err_code);
    if (byte_drop) drops++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pe);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    rx_check_err  = pe;
    @(posedge clk);
    #1;
    rx_byte_valid = 1'b0;
    rx_check_err  = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 1'b0);
  endtask

  task automatic clear_logs();
    got.delete();
    errs.delete();
    drops = 0;
  endtask

  task automatic expect_got(input string name, input logic [8:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    foreach (exp[i]) chk(name, (i < got.size()) ? got[i] : 9'h1FF, exp[i]);
  endtask

  task automatic expect_errs(input string name, input logic [1:0] exp[$]);
    chk({name, "_count"}, errs.size(), exp.size());
    foreach (exp[i]) chk(name, (i < errs.size()) ? errs[i] : 2'bxx, exp[i]);
  endtask

  logic [7:0] fr[$];
  logic [8:0] eg[$];
  logic [1:0] ee[$];
  int         sum;

  initial begin
    idle(3);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_byte_drop", byte_drop, 1'b0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    idle(2);

    // Basic frame, ready always high.
    clear_logs();
    fr = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_list(fr);
    idle(6);
    eg = {9'h011, 9'h022, 9'h133};
    expect_got("basic", eg);
    ee = {};
    expect_errs("basic_err", ee);

    // Backpressure: output held for five cycles.
    clear_logs();
    m_ready = 1'b0;
    send_list(fr);
    idle(5);
    chk("stall_valid", m_valid, 1'b1);
    chk("stall_data", m_data, 8'h11);
    m_ready = 1'b1;
    idle(6);
    expect_got("stall", eg);

    // Bad checksum, then a good single-byte frame.
    clear_logs();
    fr = {8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};
    send_list(fr);
    idle(3);
    ee = {2'd2};
    expect_errs("chksum_err", ee);
    fr = {8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
    send_list(fr);
    idle(4);
    eg = {9'h17F};
    expect_got("after_chksum", eg);

    // Length zero and length above the maximum.
    clear_logs();
    fr = {8'h55, 8'hAA, 8'h00};
    send_list(fr);
    idle(2);
    fr = {8'h55, 8'hAA, 8'h11};
    send_list(fr);
    idle(2);
    ee = {2'd1, 2'd1};
    expect_errs("len_err", ee);

    // Timeout mid-payload, parity on a payload byte, parity beating a bad length.
    clear_logs();
    fr = {8'h55, 8'hAA, 8'h02, 8'h10};
    send_list(fr);
    idle(Tmo + 2);
    send_list(fr);
    send(8'h20, 1'b1);
    idle(2);
    fr = {8'h55, 8'hAA};
    send_list(fr);
    send(8'h00, 1'b1);
    idle(2);
    ee = {2'd0, 2'd3, 2'd3};
    expect_errs("tmo_par_err", ee);
    chk("tmo_par_nodata", got.size(), 0);

    // Parity pulse while idle is ignored.
    clear_logs();
    send(8'h00, 1'b1);
    idle(2);
    chk("idle_parity", errs.size(), 0);

    // Bytes landing exactly in the timeout cycle cancel the timeout.
    clear_logs();
    fr = {8'h55, 8'hAA, 8'h01};
    send_list(fr);
    idle(Tmo - 1);
    send(8'h42, 1'b0);
    idle(Tmo - 1);
    send(8'h43, 1'b0);
    idle(3);
    eg = {9'h142};
    expect_got("tmo_cancel", eg);
    chk("tmo_cancel_err", errs.size(), 0);

    // Maximum-length frame.
    clear_logs();
    sum = MaxLen;
    fr = {8'h55, 8'hAA, 8'(MaxLen)};
    for (int i = 0; i < MaxLen; i++) begin
      fr.push_back(8'(i * 17 + 1));
      sum += i * 17 + 1;
    end
    fr.push_back(8'(sum % 256));
    send_list(fr);
    idle(MaxLen + 3);
    chk("maxlen_count", got.size(), MaxLen);
    chk("maxlen_last", (got.size() > 0) ? got[got.size() - 1] : 9'h000, 9'h100 | 9'((MaxLen - 1) * 17 + 1));

    // Repeated 0x55, drop during OUT, and the dropped 0x55 must not open a frame.
    clear_logs();
    m_ready = 1'b0;
    fr = {8'h55, 8'h55, 8'hAA, 8'h01, 8'hFF, 8'h00};
    send_list(fr);
    idle(2);
    send(8'h55, 1'b0);
    idle(2);
    chk("drop_count", drops, 1);
    m_ready = 1'b1;
    idle(3);
    fr = {8'hAA, 8'h01, 8'h05, 8'h06};
    send_list(fr);
    idle(3);
    eg = {9'h1FF};
    expect_got("drop", eg);

    // Reset during OUT and mid-frame discards everything.
    clear_logs();
    m_ready = 1'b0;
    fr = {8'h55, 8'hAA, 8'h01, 8'h33, 8'h34};
    send_list(fr);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", m_valid, 1'b0);
    idle(1);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    fr = {8'h55, 8'hAA, 8'h02, 8'h01};
    send_list(fr);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    fr = {8'h02, 8'h05};
    send_list(fr);
    idle(6);
    chk("rst_discard", got.size(), 0);
    chk("rst_no_err", errs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
